// File: rtl/mic_stall_pipe.sv
// MIC interconnect test slice: forward/backward AXI-Stream paths through chained
// 2-entry skid slices, each gated at its input by a runtime-selectable stall generator.
module mic_stall_pipe #(
  parameter int          DATA_W   = 64,
  parameter int          DEPTH    = 1,
  parameter logic [15:0] FWD_SEED = 16'hbeef,
  parameter logic [15:0] BK_SEED  = 16'h1d2c
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              M0I_TVALID,
  output logic              M0I_TREADY,
  input  logic [DATA_W-1:0] M0I_TDATA,
  input  logic              M0I_TLAST,
  output logic              S0O_TVALID,
  input  logic              S0O_TREADY,
  output logic [DATA_W-1:0] S0O_TDATA,
  output logic              S0O_TLAST,
  input  logic              S0I_TVALID,
  output logic              S0I_TREADY,
  input  logic [DATA_W-1:0] S0I_TDATA,
  input  logic              S0I_TLAST,
  output logic              M0O_TVALID,
  input  logic              M0O_TREADY,
  output logic [DATA_W-1:0] M0O_TDATA,
  output logic              M0O_TLAST,
  input  logic [1:0]        fwd_mode,
  input  logic [1:0]        bk_mode,
  input  logic [7:0]        fwd_thresh,
  input  logic [7:0]        bk_thresh,
  input  logic [7:0]        fwd_period,
  input  logic [7:0]        bk_period,
  output logic [15:0]       fwd_pkts,
  output logic [15:0]       bk_pkts
);

  typedef enum logic [1:0] {
    MODE_NONE   = 2'd0,
    MODE_RAND   = 2'd1,
    MODE_PKT    = 2'd2,
    MODE_PERIOD = 2'd3
  } stall_mode_e;

  localparam int          W        = DATA_W + 1;  // TLAST rides above the data bits
  localparam logic [15:0] FWD_INIT = (FWD_SEED == 16'h0000) ? 16'h0001 : FWD_SEED;
  localparam logic [15:0] BK_INIT  = (BK_SEED == 16'h0000) ? 16'h0001 : BK_SEED;

  // Index 0 is the forward (M0I -> S0O) path, index 1 the backward (S0I -> M0O) path.
  logic [1:0]        dir_in_valid, dir_in_ready, dir_in_last;
  logic [1:0]        dir_out_valid, dir_out_ready, dir_out_last;
  logic [DATA_W-1:0] dir_in_data  [2];
  logic [DATA_W-1:0] dir_out_data [2];
  stall_mode_e       dir_mode     [2];
  logic [7:0]        dir_thresh   [2];
  logic [7:0]        dir_period   [2];
  logic [15:0]       dir_pkts     [2];

  assign dir_in_valid  = {S0I_TVALID, M0I_TVALID};
  assign dir_in_last   = {S0I_TLAST, M0I_TLAST};
  assign dir_in_data[0] = M0I_TDATA;
  assign dir_in_data[1] = S0I_TDATA;
  assign dir_out_ready = {M0O_TREADY, S0O_TREADY};
  assign dir_mode[0]   = stall_mode_e'(fwd_mode);
  assign dir_mode[1]   = stall_mode_e'(bk_mode);
  assign dir_thresh[0] = fwd_thresh;
  assign dir_thresh[1] = bk_thresh;
  assign dir_period[0] = fwd_period;
  assign dir_period[1] = bk_period;

  assign M0I_TREADY = dir_in_ready[0];
  assign S0I_TREADY = dir_in_ready[1];
  assign S0O_TVALID = dir_out_valid[0];
  assign S0O_TDATA  = dir_out_data[0];
  assign S0O_TLAST  = dir_out_last[0];
  assign M0O_TVALID = dir_out_valid[1];
  assign M0O_TDATA  = dir_out_data[1];
  assign M0O_TLAST  = dir_out_last[1];
  assign fwd_pkts   = dir_pkts[0];
  assign bk_pkts    = dir_pkts[1];

  for (genvar g = 0; g < 2; g++) begin : g_dir
    localparam logic [15:0] SEED = (g == 0) ? FWD_INIT : BK_INIT;

    logic [DEPTH:0] pipe_valid, pipe_ready;
    logic [W-1:0]   pipe_data [DEPTH+1];
    logic [15:0]    lfsr, pkt_cnt;
    logic [7:0]     count, period_q;
    logic           first, stall, accept;

    always_comb begin
      // NOTE: assigning the default before the case keeps every path driven, so no latch is inferred.
      stall = 1'b0;
      case (dir_mode[g])
        MODE_RAND:   stall = lfsr[7:0] < dir_thresh[g];
        MODE_PKT:    stall = first && (lfsr[7:0] < dir_thresh[g]);
        MODE_PERIOD: stall = (dir_period[g] > 8'd1) && (count == dir_period[g] - 8'd1);
        default:     stall = 1'b0;
      endcase
    end

    // Stall only gates the input side; the output valid is never held back.
    assign pipe_valid[0]     = dir_in_valid[g] && !stall;
    assign pipe_data[0]      = {dir_in_last[g], dir_in_data[g]};
    assign dir_in_ready[g]   = pipe_ready[0] && !stall && reset;
    assign accept            = dir_in_valid[g] && dir_in_ready[g];
    assign pipe_ready[DEPTH] = dir_out_ready[g];
    assign dir_out_valid[g]  = pipe_valid[DEPTH];
    assign {dir_out_last[g], dir_out_data[g]} = pipe_data[DEPTH];
    assign dir_pkts[g]       = pkt_cnt;

    always_ff @(posedge clk) begin
      // Tracked through reset so a period set up during reset counts from cycle 0 after release.
      period_q <= dir_period[g];
      if (!reset) begin
        lfsr    <= SEED;
        count   <= 8'd0;
        first   <= 1'b1;
        pkt_cnt <= 16'd0;
      end else begin
        // NOTE: non-blocking assignments make every flop here sample pre-edge values.
        lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
        if ((dir_period[g] != period_q) || (dir_period[g] <= 8'd1) ||
            (count == dir_period[g] - 8'd1))
          count <= 8'd0;
        else
          count <= count + 8'd1;
        if (accept)
          first <= dir_in_last[g];
        if (dir_out_valid[g] && dir_out_ready[g] && dir_out_last[g])
          pkt_cnt <= pkt_cnt + 16'd1;
      end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slice
      logic         hold_valid, skid_valid, out_free, in_fire;
      logic [W-1:0] hold_data, skid_data;

      // Ready comes straight from a flop, so downstream ready never reaches upstream ready.
      assign pipe_ready[i]     = !skid_valid;
      assign pipe_valid[i+1]   = hold_valid;
      assign pipe_data[i+1]    = hold_data;
      assign out_free          = !hold_valid || pipe_ready[i+1];
      assign in_fire           = pipe_valid[i] && pipe_ready[i];

      always_ff @(posedge clk) begin
        if (!reset) begin
          hold_valid <= 1'b0;
          skid_valid <= 1'b0;
        end else if (out_free) begin
          hold_valid <= skid_valid || pipe_valid[i];
          skid_valid <= 1'b0;
        end else if (in_fire) begin
          skid_valid <= 1'b1;
        end
      end

      // NOTE: payload registers are not reset; their valid flags already mark them empty.
      always_ff @(posedge clk) begin
        if (out_free)
          hold_data <= skid_valid ? skid_data : pipe_data[i];
        else if (in_fire)
          skid_data <= pipe_data[i];
      end
    end
  end

endmodule

// File: tb/tb_mic_stall_pipe.sv
// Directed bench for mic_stall_pipe (DEPTH=2): latency, backpressure, periodic and
// packet-start stalls, random backward stalls, and mid-packet reset.
module tb_mic_stall_pipe;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 2;

  logic              clk;
  logic              reset;
  logic              M0I_TVALID, M0I_TREADY, M0I_TLAST;
  logic [DATA_W-1:0] M0I_TDATA;
  logic              S0O_TVALID, S0O_TREADY, S0O_TLAST;
  logic [DATA_W-1:0] S0O_TDATA;
  logic              S0I_TVALID, S0I_TREADY, S0I_TLAST;
  logic [DATA_W-1:0] S0I_TDATA;
  logic              M0O_TVALID, M0O_TREADY, M0O_TLAST;
  logic [DATA_W-1:0] M0O_TDATA;
  logic [1:0]        fwd_mode, bk_mode;
  logic [7:0]        fwd_thresh, bk_thresh, fwd_period, bk_period;
  logic [15:0]       fwd_pkts, bk_pkts;

  int checks = 0;
  int errors = 0;
  int bk_pops = 0;
  logic [DATA_W:0] fwd_q[$];
  logic [DATA_W:0] bk_q[$];

  mic_stall_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .M0I_TVALID(M0I_TVALID), .M0I_TREADY(M0I_TREADY), .M0I_TDATA(M0I_TDATA), .M0I_TLAST(M0I_TLAST),
    .S0O_TVALID(S0O_TVALID), .S0O_TREADY(S0O_TREADY), .S0O_TDATA(S0O_TDATA), .S0O_TLAST(S0O_TLAST),
    .S0I_TVALID(S0I_TVALID), .S0I_TREADY(S0I_TREADY), .S0I_TDATA(S0I_TDATA), .S0I_TLAST(S0I_TLAST),
    .M0O_TVALID(M0O_TVALID), .M0O_TREADY(M0O_TREADY), .M0O_TDATA(M0O_TDATA), .M0O_TLAST(M0O_TLAST),
    .fwd_mode(fwd_mode), .bk_mode(bk_mode), .fwd_thresh(fwd_thresh), .bk_thresh(bk_thresh),
    .fwd_period(fwd_period), .bk_period(bk_period), .fwd_pkts(fwd_pkts), .bk_pkts(bk_pkts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W:0] obs, input logic [DATA_W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; leaves reset released at the falling edge that starts cycle 0.
  task automatic apply_reset();
    reset      = 1'b0;
    M0I_TVALID = 1'b0;
    S0I_TVALID = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Scoreboard: beats accepted at the inputs must leave the outputs in order, unchanged.
  always begin
    @(negedge clk);
    #3;
    if (!reset) begin
      fwd_q.delete();
      bk_q.delete();
    end else begin
      if (S0O_TVALID && S0O_TREADY) begin
        check("fwd_sb_pending", fwd_q.size() != 0, 1);
        if (fwd_q.size() != 0) check("fwd_sb_order", {S0O_TLAST, S0O_TDATA}, fwd_q.pop_front());
      end
      if (M0I_TVALID && M0I_TREADY) fwd_q.push_back({M0I_TLAST, M0I_TDATA});
      if (M0O_TVALID && M0O_TREADY) begin
        bk_pops++;
        check("bk_sb_pending", bk_q.size() != 0, 1);
        if (bk_q.size() != 0) check("bk_sb_order", {M0O_TLAST, M0O_TDATA}, bk_q.pop_front());
      end
      if (S0I_TVALID && S0I_TREADY) bk_q.push_back({S0I_TLAST, S0I_TDATA});
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx, outs, n, stalls, nlast;
    logic [DATA_W-1:0] bdat [100];
    logic              blast [100];

    reset = 1'b0;
    M0I_TVALID = 1'b0; M0I_TDATA = '0; M0I_TLAST = 1'b0; S0O_TREADY = 1'b0;
    S0I_TVALID = 1'b0; S0I_TDATA = '0; S0I_TLAST = 1'b0; M0O_TREADY = 1'b0;
    fwd_mode = 2'd0; bk_mode = 2'd0; fwd_thresh = 8'd0; bk_thresh = 8'd0;
    fwd_period = 8'd0; bk_period = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_m0i_tready", M0I_TREADY, 0);
    check("rst_s0i_tready", S0I_TREADY, 0);
    check("rst_s0o_tvalid", S0O_TVALID, 0);
    check("rst_m0o_tvalid", M0O_TVALID, 0);
    check("rst_fwd_pkts", fwd_pkts, 0);
    check("rst_bk_pkts", bk_pkts, 0);
    @(negedge clk);
    reset = 1'b1; S0O_TREADY = 1'b1; M0O_TREADY = 1'b1;

    // Mode 0: 4-beat packet, two-cycle latency, back-to-back output
    for (int c = 0; c < 7; c++) begin
      M0I_TVALID = (c < 4); M0I_TDATA = 64'(c + 1); M0I_TLAST = (c == 3);
      #1;
      if (c < 4) check("t1_ready", M0I_TREADY, 1);
      check("t1_valid", S0O_TVALID, (c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) begin
        check("t1_data", S0O_TDATA, c - 1);
        check("t1_last", S0O_TLAST, c == 5);
      end
      @(negedge clk);
    end
    check("t1_pkts", fwd_pkts, 1);

    // Backpressure: capacity 2*DEPTH, then in-order release
    S0O_TREADY = 1'b0; idx = 0;
    for (int c = 0; c < 8; c++) begin
      M0I_TVALID = (idx < 6); M0I_TDATA = 64'(11 + idx); M0I_TLAST = (idx == 5);
      #1;
      if (M0I_TVALID && M0I_TREADY) idx++;
      @(negedge clk);
    end
    #1;
    check("t2_accepted", idx, 4);
    check("t2_full_ready", M0I_TREADY, 0);
    @(negedge clk);
    outs = 0; n = 0;
    S0O_TREADY = 1'b1;
    while (outs < 6 && n < 40) begin
      M0I_TVALID = (idx < 6); M0I_TDATA = 64'(11 + idx); M0I_TLAST = (idx == 5);
      #1;
      if (S0O_TVALID) begin
        check("t2_order", S0O_TDATA, 11 + outs);
        outs++;
      end
      if (M0I_TVALID && M0I_TREADY) idx++;
      @(negedge clk);
      n++;
    end
    M0I_TVALID = 1'b0;
    check("t2_out_count", outs, 6);
    check("t2_pkts", fwd_pkts, 2);

    // Periodic stall: period 4, ready low on cycles 3,7,11
    fwd_mode = 2'd3; fwd_period = 8'd4;
    apply_reset();
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      M0I_TVALID = 1'b1; M0I_TDATA = 64'(32'h100 + idx); M0I_TLAST = 1'b0;
      #1;
      check("t3_ready", M0I_TREADY, (c % 4) != 3);
      if (M0I_TREADY) idx++;
      @(negedge clk);
    end
    M0I_TVALID = 1'b0;
    check("t3_accepted", idx, 9);
    repeat (6) @(negedge clk);
    check("t3_drained", fwd_q.size(), 0);

    // Packet-start stall: thresh 255, three 8-beat packets
    fwd_mode = 2'd2; fwd_thresh = 8'd255;
    apply_reset();
    stalls = 0;
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 8; b++) begin
        M0I_TVALID = 1'b1; M0I_TDATA = 64'(p * 16 + b + 1); M0I_TLAST = (b == 7);
        #1;
        if (b == 0) begin
          n = 0;
          while (M0I_TREADY !== 1'b1 && n < 8000) begin
            stalls++;
            @(negedge clk);
            #1;
            n++;
          end
          check("t4_pkt_start", M0I_TREADY, 1);
        end else begin
          check("t4_b2b", M0I_TREADY, 1);
        end
        @(negedge clk);
      end
    end
    M0I_TVALID = 1'b0;
    repeat (6) @(negedge clk);
    check("t4_pkts", fwd_pkts, 3);
    check("t4_stalls_seen", stalls != 0, 1);

    // Backward random stall with random sink ready
    bk_mode = 2'd1; bk_thresh = 8'd128;
    nlast = 0;
    for (int i = 0; i < 100; i++) begin
      bdat[i]  = {$urandom, $urandom};
      blast[i] = (i == 99) || ($urandom_range(0, 3) == 0);
      if (blast[i]) nlast++;
    end
    idx = 0; n = 0;
    while (idx < 100 && n < 5000) begin
      M0O_TREADY = 1'($urandom_range(0, 1));
      S0I_TVALID = 1'b1; S0I_TDATA = bdat[idx]; S0I_TLAST = blast[idx];
      #1;
      if (S0I_TREADY) idx++;
      @(negedge clk);
      n++;
    end
    S0I_TVALID = 1'b0; M0O_TREADY = 1'b1;
    check("t5_accepted", idx, 100);
    repeat (10) @(negedge clk);
    check("t5_delivered", bk_pops, 100);
    check("t5_pkts", bk_pkts, nlast);
    check("t5_drained", bk_q.size(), 0);

    // Reset with three beats buffered mid-packet
    fwd_mode = 2'd0; S0O_TREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      M0I_TVALID = 1'b1; M0I_TDATA = 64'(32'hA1 + k); M0I_TLAST = 1'b0;
      #1;
      check("t6_fill", M0I_TREADY, 1);
      @(negedge clk);
    end
    M0I_TVALID = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("t6_s0o_tvalid", S0O_TVALID, 0);
    check("t6_m0o_tvalid", M0O_TVALID, 0);
    check("t6_fwd_pkts", fwd_pkts, 0);
    check("t6_bk_pkts", bk_pkts, 0);
    check("t6_m0i_tready", M0I_TREADY, 0);
    @(negedge clk);
    reset = 1'b1; S0O_TREADY = 1'b1;
    idx = 0; outs = 0; n = 0;
    while (outs < 2 && n < 20) begin
      M0I_TVALID = (idx < 2); M0I_TDATA = 64'(32'hB1 + idx); M0I_TLAST = (idx == 1);
      #1;
      if (S0O_TVALID) begin
        check("t6_data", S0O_TDATA, 32'hB1 + outs);
        check("t6_last", S0O_TLAST, outs == 1);
        outs++;
      end
      if (M0I_TVALID && M0I_TREADY) idx++;
      @(negedge clk);
      n++;
    end
    M0I_TVALID = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_out_count", outs, 2);
    check("t6_pkts", fwd_pkts, 1);
    check("t6_drained", fwd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mic_stall_pipe.md
Name: mic_stall_pipe

Overview:
- Parametrised MIC interconnect test slice, successor to the fixed single-slice stall simulator.
- Sits between one requester port (M0) and one completer port (S0) in simulation benches, with a forward request path and a backward response path.
- Adds a configurable pipeline depth and data width, with per-direction runtime-selectable stall modes: none, random-any-beat, random-packet-start-only, periodic.
- Exports per-direction packet counters for scoreboards.

Parameters:
DATA_W, 64, TDATA width in bits (>=8)
DEPTH, 1, number of 2-entry skid slices per direction (1..4)
FWD_SEED, 16'hbeef, forward LFSR seed (0 is replaced by 16'h0001)
BK_SEED, 16'h1d2c, backward LFSR seed (0 is replaced by 16'h0001)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
M0I_TVALID/M0I_TREADY/M0I_TDATA/M0I_TLAST  in/out/in/in  1/1/DATA_W/1  request from requester
S0O_TVALID/S0O_TREADY/S0O_TDATA/S0O_TLAST  out/in/out/out  1/1/DATA_W/1  request to completer
S0I_TVALID/S0I_TREADY/S0I_TDATA/S0I_TLAST  in/out/in/in  1/1/DATA_W/1  response from completer
M0O_TVALID/M0O_TREADY/M0O_TDATA/M0O_TLAST  out/in/out/out  1/1/DATA_W/1  response to requester
fwd_mode, bk_mode  in  2  stall mode: 0 none, 1 random any beat, 2 random at packet start only, 3 periodic
fwd_thresh, bk_thresh  in  8  random stall when lfsr[7:0] < thresh
fwd_period, bk_period  in  8  periodic mode: stall one cycle in every period cycles (0 or 1 = never stall)
fwd_pkts, bk_pkts  out  16  count of TLAST beats transferred on S0O / M0O, wrapping

Behaviour:
- Reset is synchronous and active-low: all state clears on the clk edge where reset==0.
- Reset values: all TVALID 0, all TREADY 0, counters 0, LFSRs at seed, period counters 0, first-beat flags 1.
- Any packet in flight is discarded on reset; there is no partial-packet recovery.
- Each direction is an identical, independent path. Terms "in"/"out" below refer to that path's input and output sides.
- Slice: 2-entry skid buffer, each with a registered ready and TLAST stored alongside data. Full throughput, FIFO order, no combinational path from out_TREADY to in_TREADY.
- Chaining DEPTH slices gives an empty-pipe latency of exactly DEPTH cycles: a beat accepted at edge N is valid on out at cycle N+DEPTH.
- Capacity is 2*DEPTH beats.
- Stall gate at the input only:
  - in_TREADY = slice0_ready && !stall && reset.
  - Slice0 sees valid = in_TVALID && !stall.
  - out_TVALID is never gated.
- LFSR: 16-bit Galois, polynomial mask 16'hB400. Shifts every cycle when not in reset, regardless of mode.
- Period counter: counts 0..period-1, then wraps; it advances every cycle. If period changes, the counter restarts from 0 on the next cycle.
- first flag: cleared on acceptance of a non-last beat; set on acceptance of a TLAST beat. It is tracked in all modes.
- stall per mode:
  - Mode 0: stall = 0.
  - Mode 1: stall = (lfsr[7:0] < thresh).
  - Mode 2: stall = first && (lfsr[7:0] < thresh).
  - Mode 3: stall = (period > 1) && (count == period-1).
- thresh=0 never stalls in modes 1 and 2.
- Config inputs are sampled combinationally; a change takes effect in the same cycle. Benches change config only while the input is idle.
- Counters increment on out_TVALID && out_TREADY && out_TLAST and wrap from 16'hFFFF to 0.
- Full pipe with out_TREADY low: in_TREADY drops within 1 cycle of the 2*DEPTH-th acceptance. No beat is dropped or duplicated.
- Simultaneous push and pop on a full pipe: one beat transfers at out; input acceptance resumes on the next cycle (registered ready).
- in_TVALID asserted during stall: no acceptance; the source must hold data per AXI-Stream rules.

Test Plan:
- DEPTH=2, both modes 0, 4-beat packet (data 1,2,3,4, TLAST on 4), S0O_TREADY=1 -> M0I_TREADY constant 1; beats appear on S0O 2 cycles after acceptance, back-to-back; fwd_pkts=1.
- DEPTH=2, mode 0, S0O_TREADY held 0, 6 beats offered -> exactly 4 accepted, then M0I_TREADY=0. Release ready -> output sequence 1..6 in order with no gaps beyond the pipe refill.
- fwd_mode=3, period=4, continuous valid -> M0I_TREADY low on cycles 3,7,11,... after reset release; 12 cycles accept 9 beats.
- fwd_mode=2, thresh=255, three 8-beat packets -> stalls observed only while first=1. Beats 2..8 of each packet are accepted back-to-back; fwd_pkts=3.
- bk_mode=1, thresh=128, 100 random beats with random M0O_TREADY -> data/TLAST order is identical to the S0I stream; bk_pkts equals the TLAST count in the stream.
- reset=0 asserted mid-packet with 3 beats buffered -> next cycle: all TVALID 0, counters 0; after release, a new 2-beat packet passes cleanly with no stale beats.
